// File: rtl/div_unit_pkg.sv
// Shared types and width constants for the iterative RV32M divider.
package div_unit_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  // One-hot operation select, MSB first: {div, divu, rem, remu}.
  typedef struct packed {
    logic div;
    logic divu;
    logic rem;
    logic remu;
  } div_op_type;

  typedef struct packed {
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic            enable;
    div_op_type      op;
  } div_in_type;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            ready;
  } div_out_type;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FINISH
  } div_state_type;

  // Two's-complement negate when neg is set.
  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider: one quotient bit per cycle, DIV/DIVU/REM/REMU.
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  div_in_type  div_in,
  input  logic        clear,
  output div_out_type div_out
);

  typedef struct packed {
    div_state_type   state;
    logic [CNT_W-1:0] cnt;
    div_op_type      op;
    logic [XLEN-1:0] dvd;     // dividend shifting out, quotient shifting in
    logic [XLEN-1:0] dsr;     // divisor magnitude
    logic [XLEN-1:0] rem;     // partial remainder
    logic            neg_q;
    logic            neg_r;
    logic [XLEN-1:0] result;
  } div_reg_type;

  localparam div_reg_type REG_RESET = '{
    state:  IDLE,
    cnt:    '0,
    op:     '0,
    dvd:    '0,
    dsr:    '0,
    rem:    '0,
    neg_q:  1'b0,
    neg_r:  1'b0,
    result: '0
  };

  div_reg_type r;
  div_reg_type v;

  logic [XLEN:0]   rem_sh;
  logic            q_bit;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] dvd_nxt;
  logic            in_signed;
  logic            in_quot;
  logic            s1;
  logic            s2;

  // Next-state logic: one restoring step plus the IDLE/BUSY/FINISH sequencing.
  always_comb begin
    // NOTE: v starts as a copy of r so every field has a value on every path; no latches.
    v = r;

    rem_sh  = {r.rem, r.dvd[XLEN-1]};
    q_bit   = (rem_sh >= {1'b0, r.dsr});
    rem_nxt = q_bit ? XLEN'(rem_sh - {1'b0, r.dsr}) : rem_sh[XLEN-1:0];
    dvd_nxt = {r.dvd[XLEN-2:0], q_bit};

    in_signed = div_in.op.div | div_in.op.rem;
    in_quot   = div_in.op.div | div_in.op.divu;
    s1        = in_signed & div_in.rdata1[XLEN-1];
    s2        = in_signed & div_in.rdata2[XLEN-1];

    unique case (r.state)
      IDLE: begin
        if (div_in.enable) begin
          v.op    = div_in.op;
          v.dvd   = neg_if(div_in.rdata1, s1);
          v.dsr   = neg_if(div_in.rdata2, s2);
          v.neg_q = s1 ^ s2;
          v.neg_r = s1;
          v.rem   = '0;
          v.cnt   = CNT_W'(XLEN - 1);
          if (div_in.rdata2 == '0) begin
            v.result = in_quot ? '1 : div_in.rdata1;
            v.state  = FINISH;
          end else if (in_signed && div_in.rdata1 == INT_MIN && div_in.rdata2 == '1) begin
            v.result = in_quot ? INT_MIN : '0;
            v.state  = FINISH;
          end else begin
            v.state  = BUSY;
          end
        end
      end
      BUSY: begin
        v.rem = rem_nxt;
        v.dvd = dvd_nxt;
        v.cnt = r.cnt - 1'b1;
        if (r.cnt == '0) begin
          v.state  = FINISH;
          v.result = (r.op.div | r.op.divu) ? neg_if(dvd_nxt, r.neg_q)
                                             : neg_if(rem_nxt, r.neg_r);
        end
      end
      FINISH: v.state = IDLE;
      default: v.state = IDLE;
    endcase

    // Abort wins over everything except reset; a same-cycle enable is dropped.
    if (clear) v.state = IDLE;
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) r <= REG_RESET;
    else       r <= v;
  end

  assign div_out.result = r.result;
  assign div_out.ready  = (r.state == FINISH) & ~clear;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random ops vs. an arithmetic model.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam div_op_type OP_DIV  = 4'b1000;
  localparam div_op_type OP_DIVU = 4'b0100;
  localparam div_op_type OP_REM  = 4'b0010;
  localparam div_op_type OP_REMU = 4'b0001;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  div_in_type  div_in = '0;
  div_out_type div_out;

  int n_vec = 0;
  int n_err = 0;

  div_unit dut (
    .clock  (clock),
    .reset  (reset),
    .div_in (div_in),
    .clear  (clear),
    .div_out(div_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics in plain arithmetic.
  function automatic logic [31:0] model_result(input div_op_type op, input logic [31:0] a,
                                               input logic [31:0] b);
    bit want_q = op.div | op.divu;
    bit sgn    = op.div | op.rem;
    int sa, sb;
    if (b == 0) return want_q ? 32'hFFFF_FFFF : a;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return want_q ? 32'h8000_0000 : 32'h0;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      return want_q ? 32'(sa / sb) : 32'(sa % sb);
    end
    return want_q ? (a / b) : (a % b);
  endfunction

  function automatic int model_latency(input div_op_type op, input logic [31:0] a,
                                       input logic [31:0] b);
    if (b == 0) return 1;
    if ((op.div | op.rem) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  // Drive a start request in the current cycle (cycle 0).
  task automatic start_op(input div_op_type op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    div_in.rdata1 = a;
    div_in.rdata2 = b;
    div_in.op     = op;
    div_in.enable = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      div_in.enable = 1'b0;
    end
  endtask

  // Cycles until ready, counted from the next cycle; -1 if the budget expires.
  task automatic wait_ready(input int budget, output int lat);
    lat = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clock);
      div_in.enable = 1'b0;
      #1;
      if (div_out.ready) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_check(input string tag, input div_op_type op, input logic [31:0] a,
                           input logic [31:0] b);
    int lat;
    start_op(op, a, b);
    wait_ready(40, lat);
    check({tag, " latency"}, 64'(lat), 64'(model_latency(op, a, b)));
    if (lat > 0) check({tag, " result"}, 64'(div_out.result), 64'(model_result(op, a, b)));
  endtask

  initial begin
    int lat;
    div_op_type op;
    logic [31:0] a, b;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset ready", 64'(div_out.ready), 64'd0);
    check("reset result", 64'(div_out.result), 64'd0);

    // Directed cases.
    run_check("divu 100/7", OP_DIVU, 32'd100, 32'd7);
    run_check("remu 100/7", OP_REMU, 32'd100, 32'd7);
    run_check("div -7/3", OP_DIV, 32'hFFFF_FFF9, 32'd3);
    run_check("rem -7/3", OP_REM, 32'hFFFF_FFF9, 32'd3);
    run_check("rem 7/-3", OP_REM, 32'd7, 32'hFFFF_FFFD);
    run_check("div 5/0", OP_DIV, 32'd5, 32'd0);
    run_check("remu 5/0", OP_REMU, 32'd5, 32'd0);
    run_check("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_check("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    run_check("divu max/max", OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_check("divu 1/max", OP_DIVU, 32'd1, 32'hFFFF_FFFF);
    run_check("remu max/big", OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001);

    // Spot-check the explicit result values from the cases above.
    start_op(OP_DIVU, 32'd100, 32'd7);
    wait_ready(40, lat);
    check("divu 14 lat", 64'(lat), 64'd33);
    check("divu 14 val", 64'(div_out.result), 64'd14);
    start_op(OP_DIV, 32'hFFFF_FFF9, 32'd3);
    wait_ready(40, lat);
    check("div -2 val", 64'(div_out.result), 64'hFFFF_FFFE);

    // Clear in cycle 10 of BUSY aborts the operation.
    start_op(OP_DIVU, 32'd100, 32'd7);
    idle_cycles(9);
    @(negedge clock);
    clear = 1'b1;
    #1;
    check("clear busy ready", 64'(div_out.ready), 64'd0);
    @(negedge clock);
    clear = 1'b0;
    wait_ready(40, lat);
    check("clear busy no ready", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
    run_check("divu max/1 after clear", OP_DIVU, 32'hFFFF_FFFF, 32'd1);

    // Clear together with enable in IDLE drops the request.
    start_op(OP_DIV, 32'd5, 32'd0);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    div_in.enable = 1'b0;
    wait_ready(40, lat);
    check("clear+enable dropped", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);

    // Clear while in FINISH suppresses the ready pulse.
    start_op(OP_DIV, 32'd5, 32'd0);
    @(negedge clock);
    div_in.enable = 1'b0;
    clear = 1'b1;
    #1;
    check("clear finish ready", 64'(div_out.ready), 64'd0);
    @(negedge clock);
    clear = 1'b0;
    #1;
    check("clear finish next", 64'(div_out.ready), 64'd0);

    // Enable during BUSY is ignored: one ready with the original result.
    start_op(OP_DIVU, 32'd100, 32'd7);
    idle_cycles(4);
    @(negedge clock);
    div_in.rdata1 = 32'd5;
    div_in.rdata2 = 32'd0;
    div_in.op     = OP_DIV;
    div_in.enable = 1'b1;
    wait_ready(40, lat);
    check("busy enable lat", 64'(lat + 5), 64'd33);
    check("busy enable val", 64'(div_out.result), 64'd14);
    wait_ready(40, lat);
    check("busy enable single", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);

    // Reset in cycle 20 discards the operation.
    start_op(OP_DIVU, 32'd100, 32'd7);
    idle_cycles(19);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("midop reset ready", 64'(div_out.ready), 64'd0);
    check("midop reset result", 64'(div_out.result), 64'd0);
    wait_ready(40, lat);
    check("midop reset no ready", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);

    // Random back-to-back operations.
    for (int i = 0; i < 48; i++) begin
      op = div_op_type'(4'b1000 >> $urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      run_check($sformatf("rand %0d", i), op, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
